// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, JAL opcode,
// sequential PC increment and the RISC-V J-type immediate extractor.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [6:0]  OPC_JAL = 7'b1101111;
  localparam logic [31:0] PC_INC  = 32'd4;

  // Sign-extended J-immediate: imm[20|10:1|11|19:12], bit 0 always zero.
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_jal_predecode.sv
// JAL pre-decode: flags a JAL in the fetched word and computes its target.
// Only compiled when FETCH_JAL_PREDECODE_EN is defined, so the default build
// carries no uninstantiated module.
`ifdef FETCH_JAL_PREDECODE_EN
module jal_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        is_jal,
  output logic [31:0] target
);

  // Opcode match and pc-relative target, purely combinational.
  always_comb begin
    is_jal = (instr[6:0] == OPC_JAL);
    target = pc + j_imm(instr);
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational-read imem
// and registers {pc, instr} into the IF/ID register with valid/ready handoff.
// Execute redirects flush the register; misaligned targets latch a sticky
// fault that only reset clears.
// Optional feature macro: FETCH_JAL_PREDECODE_EN (JAL redirected in fetch).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         out_pred_q, out_pred_d;

  logic         is_jal;
  logic         jal_fault;
  logic [31:0]  next_pc;

`ifdef FETCH_JAL_PREDECODE_EN
  logic [31:0] jal_target;

  jal_predecode u_jal_predecode (
    .instr  (imem_rdata),
    .pc     (pc_q),
    .is_jal (is_jal),
    .target (jal_target)
  );

  // A JAL steers the next fetch; a misaligned JAL target stops fetching.
  always_comb begin
    next_pc   = is_jal ? jal_target : pc_q + PC_INC;
    jal_fault = is_jal && (jal_target[1:0] != 2'b00);
  end
`else
  // Without pre-decode every JAL is resolved later by an execute redirect.
  always_comb begin
    is_jal    = 1'b0;
    jal_fault = 1'b0;
    next_pc   = pc_q + PC_INC;
  end
`endif

  // Next-state: redirect beats stall beats capture; FAULT freezes everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_pred_d  = out_pred_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          // Flush drops even a stalled entry; the target costs one bubble.
          out_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) state_d = FAULT;
          else                           pc_d    = redirect_pc;
        end else if (!(out_valid_q && !out_ready)) begin
          out_pc_d    = pc_q;
          out_instr_d = imem_rdata;
          out_pred_d  = is_jal;
          if (jal_fault) begin
            // Word is recorded but never presented; the PC stays frozen.
            state_d     = FAULT;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            pc_d        = next_pc;
          end
        end
      end
      FAULT:   out_valid_d = 1'b0;
      default: begin
        state_d     = FAULT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID register, asynchronously reset to the boot image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_instr_q <= 32'h0;
      out_pred_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_pred_q  <= out_pred_d;
    end
  end

  assign imem_addr      = {2'b00, pc_q[31:2]};
  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_instr      = out_instr_q;
  assign out_pred_taken = out_pred_q;
  assign fault          = (state_q == FAULT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the program counter, drives the word address of the combinational-read instruction memory, and registers each fetched word with its PC into the IF/ID pipeline register for decode. Sits between execute (redirect source) and decode (valid/ready consumer). Handles stall back-pressure, execute-stage redirects (flush), misaligned-target faults, and optional JAL pre-decode.

## Interface
- RESET_PC, 32'h0000_0000, byte PC loaded at reset
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  word address to instruction memory: {2'b00, pc[31:2]}
- imem_rdata  in  32  instruction word, combinational from imem_addr, same cycle
- redirect_valid  in  1  execute requests PC change (taken branch/jump)
- redirect_pc  in  32  redirect target, byte address
- out_valid  out  1  IF/ID register holds a valid instruction
- out_ready  in  1  decode accepts IF/ID contents this cycle
- out_pc  out  32  byte PC of held instruction
- out_instr  out  32  held instruction word
- out_pred_taken  out  1  held instruction was a JAL redirected in fetch (0 when macro off)
- fault  out  1  sticky misaligned-fetch fault

## Operation
- FSM states: BOOT, RUN, FAULT.
- BOOT: entered on reset; pc=RESET_PC, out_valid=0; unconditionally to RUN next cycle; no capture.
- RUN, per cycle, priority order:
  - redirect_valid=1, redirect_pc[1:0]!=0 -> FAULT; out_valid<=0.
  - redirect_valid=1, aligned -> pc<=redirect_pc; out_valid<=0 (flush, including a stalled entry); no capture.
  - out_valid=1 and out_ready=0 -> stall: pc, out_* held unchanged.
  - otherwise (register empty or being consumed) -> capture out_pc<=pc, out_instr<=imem_rdata, out_valid<=1; pc<=next_pc.
- next_pc = pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0), except JAL pre-decode (Configuration).
- FAULT: out_valid=0, fault=1, pc frozen, all inputs ignored; exit only via reset.
- Reset mid-operation: asynchronous return to BOOT values, any captured instruction discarded.

## Timing
- Reset values: imem_addr={2'b00,RESET_PC[31:2]}, out_valid=0, out_pc=0, out_instr=0, out_pred_taken=0, fault=0, state=BOOT.
- imem_addr is a function of the pc register only (no input-to-address combinational path).
- Fetch latency: instruction at pc visible on out_* one cycle after pc is presented; throughput 1 instr/cycle when out_ready=1.
- First valid output: second rising edge after reset_n deasserts (BOOT cycle, then capture).
- Redirect: one bubble; target instruction valid two edges after redirect_valid sampled.
- Simultaneous redirect and out_ready=0: redirect wins, held entry dropped.
- out_* stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_JAL_PREDECODE_EN defined: on capture, if imem_rdata[6:0]==7'b1101111, next_pc=pc+sext(J-immediate) and out_pred_taken<=1; target[1:0]!=0 -> FAULT instead of capture... capture still occurs, fault asserts next cycle, no further fetch. Execute must not re-redirect when out_pred_taken=1.
- Not defined: next_pc always pc+4, out_pred_taken tied 0, JAL resolved by execute redirect (two bubbles total).

## Structure
- Shared package fetch_pkg: state enum (BOOT/RUN/FAULT), OPC_JAL constant, J-immediate extract function, PC_INC=4.
- One sub-module: jal_predecode (combinational: instr, pc -> is_jal, target); instantiated only under FETCH_JAL_PREDECODE_EN.

## Test plan
- Reset release, out_ready=1, imem program {0x0,0x00108093,0x00110113,...}: out (pc,instr) = (0x0,0x0),(0x4,0x00108093),(0x8,0x00110113) on consecutive cycles.
- out_ready=0 for 3 cycles while holding pc 0x8: out_* and imem_addr constant, then resumes with pc 0xC, no skip/duplicate.
- redirect_valid with redirect_pc=0x4 while stalled at pc 0xC: next cycle out_valid=0, following cycle out=(0x4,0x00108093).
- redirect_pc=0x6: fault=1 next cycle, out_valid stays 0 under further redirects; reset_n low clears fault, restart at RESET_PC.
- Macro on, word 0xffdff1ef at pc 0x14: captured with out_pred_taken=1, next out_pc=0x10; macro off: next out_pc=0x18, out_pred_taken=0.
- pc=0xFFFF_FFFC sequential capture: next out_pc=0x0.
